// File: rtl/hrd_pkg.sv
// Shared definitions for the Huarong Dao move controller: direction codes,
// controller states and the direction-code validity check.
package hrd_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ANIM,
        COMMIT,
        WIN,
        OVER
    } state_e;

    // Codes 5..7 are never a move; they are dropped without any reject.
    function automatic logic is_move_dir(input logic [2:0] dir);
        case (dir)
            DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hrd_move_ctrl_if.sv
// Signal bundle between the move controller (master) and its environment:
// direction driver, board legality checker and display (slave).
interface hrd_move_ctrl_if #(
    parameter int MOVE_W = 10
);
    logic [2:0]        I_dir_index;
    logic              I_restart;
    logic              I_chk_done;
    logic              I_chk_ok;
    logic              I_win;
    logic              O_chk_req;
    logic [2:0]        O_chk_dir;
    logic [2:0]        O_anim_dir;
    logic [7:0]        O_anim_off;
    logic              O_commit;
    logic              O_reject;
    logic              O_busy;
    logic [MOVE_W-1:0] O_move_cnt;
    logic              O_gameover;

    modport master (
        input  I_dir_index, I_restart, I_chk_done, I_chk_ok, I_win,
        output O_chk_req, O_chk_dir, O_anim_dir, O_anim_off, O_commit,
        output O_reject, O_busy, O_move_cnt, O_gameover
    );

    modport slave (
        output I_dir_index, I_restart, I_chk_done, I_chk_ok, I_win,
        input  O_chk_req, O_chk_dir, O_anim_dir, O_anim_off, O_commit,
        input  O_reject, O_busy, O_move_cnt, O_gameover
    );
endinterface

// File: rtl/hrd_anim_timer.sv
// Slide animation timer: divides the clock by STEP_DIV and counts offset
// steps 0..ANIM_STEPS; done flags the clock on which the last step lands.
module hrd_anim_timer #(
    parameter int ANIM_STEPS = 8,
    parameter int STEP_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    output logic [7:0] off,
    output logic       done
);
    localparam int DIV_W = $clog2(STEP_DIV + 1);

    logic             running;
    logic [DIV_W-1:0] div;
    logic             last_div;
    logic             last_step;

    assign last_div  = (div == DIV_W'(STEP_DIV - 1));
    assign last_step = (off == 8'(ANIM_STEPS - 1));
    assign done      = running && last_div && last_step;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            div     <= '0;
            off     <= '0;
        end else if (clear) begin
            running <= 1'b0;
            div     <= '0;
            off     <= '0;
        end else if (start) begin
            running <= 1'b1;
            div     <= '0;
            off     <= '0;
        end else if (running) begin
            if (last_div) begin
                div <= '0;
                off <= off + 8'd1;
                if (last_step) running <= 1'b0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hrd_move_ctrl.sv
// Huarong Dao move sequencer: check -> slide animation -> commit -> win sample.
// Define HRD_CMD_QUEUE_EN to buffer one command that arrives while busy.
module hrd_move_ctrl
    import hrd_pkg::*;
#(
    parameter int ANIM_STEPS  = 8,
    parameter int STEP_DIV    = 4,
    parameter int CHK_TIMEOUT = 16,
    parameter int MOVE_W      = 10
) (
    input  logic            I_clk,
    input  logic            I_rst_n,
    hrd_move_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(CHK_TIMEOUT + 1);

    state_e            state, next_state;
    logic [2:0]        prev_dir;
    logic [2:0]        chk_dir;
    logic [2:0]        anim_dir;
    logic [MOVE_W-1:0] move_cnt;
    logic              gameover;
    logic [CNT_W-1:0]  chk_cnt;
    logic [7:0]        anim_off;
    logic              restart, chk_done, chk_ok, cmd, chk_timeout;
    logic              anim_start, anim_done, timer_clear;
    logic              chk_req, busy, commit, reject;
    logic              issue, busy_drop;
    logic [2:0]        issue_dir;

    assign restart     = bus.I_restart;
    assign chk_done    = bus.I_chk_done;
    assign chk_ok      = bus.I_chk_ok;
    assign cmd         = (prev_dir == DIR_NONE) && is_move_dir(bus.I_dir_index);
    assign chk_timeout = (state == CHECK) && (chk_cnt == CNT_W'(CHK_TIMEOUT - 1));
    assign anim_start  = (state == CHECK) && chk_done && chk_ok && !restart;
    assign timer_clear = restart || commit;

`ifdef HRD_CMD_QUEUE_EN
    logic       q_valid;
    logic [2:0] q_dir;

    // The buffered command is older than any fresh press, so it goes first.
    assign issue     = (state == IDLE) && (q_valid || cmd);
    assign issue_dir = q_valid ? q_dir : bus.I_dir_index;
    assign busy_drop = busy && cmd && q_valid;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            q_valid <= 1'b0;
            q_dir   <= DIR_NONE;
        end else if (restart || ((state == WIN) && bus.I_win)) begin
            q_valid <= 1'b0;
        end else if (busy && cmd && !q_valid) begin
            q_valid <= 1'b1;
            q_dir   <= bus.I_dir_index;
        end else if ((state == IDLE) && q_valid) begin
            q_valid <= cmd;
            q_dir   <= bus.I_dir_index;
        end
    end
`else
    assign issue     = (state == IDLE) && cmd;
    assign issue_dir = bus.I_dir_index;
    assign busy_drop = busy && cmd;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: a default assignment at the top of every combinational process
    // keeps each path fully specified, so no latch is inferred.
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (issue) next_state = CHECK;
                CHECK: begin
                    if (chk_done)         next_state = chk_ok ? ANIM : IDLE;
                    else if (chk_timeout) next_state = IDLE;
                end
                ANIM:    if (anim_done) next_state = COMMIT;
                COMMIT:  next_state = WIN;
                WIN:     next_state = bus.I_win ? OVER : IDLE;
                OVER:    next_state = OVER;
                default: next_state = IDLE;
            endcase
        end
    end

    // Reject sources are ORed, so coincident causes give a single pulse.
    always_comb begin
        chk_req = (state == CHECK);
        busy    = (state != IDLE) && (state != OVER);
        commit  = (state == COMMIT);
        reject  = !restart &&
                  (((state == CHECK) && chk_done && !chk_ok) ||
                   (chk_timeout && !chk_done) ||
                   busy_drop);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            prev_dir <= DIR_NONE;
            chk_cnt  <= '0;
            chk_dir  <= DIR_NONE;
            anim_dir <= DIR_NONE;
            move_cnt <= '0;
            gameover <= 1'b0;
        end else begin
            prev_dir <= bus.I_dir_index;
            chk_cnt  <= (state == CHECK) ? chk_cnt + 1'b1 : '0;
            if (restart) begin
                chk_dir  <= DIR_NONE;
                anim_dir <= DIR_NONE;
                move_cnt <= '0;
                gameover <= 1'b0;
            end else begin
                if (issue)      chk_dir  <= issue_dir;
                if (anim_start) anim_dir <= chk_dir;
                else if (commit) anim_dir <= DIR_NONE;
                if (commit && (move_cnt != '1)) move_cnt <= move_cnt + 1'b1;
                if ((state == WIN) && bus.I_win) gameover <= 1'b1;
            end
        end
    end

    hrd_anim_timer #(
        .ANIM_STEPS (ANIM_STEPS),
        .STEP_DIV   (STEP_DIV)
    ) u_anim_timer (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .start (anim_start),
        .clear (timer_clear),
        .off   (anim_off),
        .done  (anim_done)
    );

    assign bus.O_chk_req  = chk_req;
    assign bus.O_chk_dir  = chk_dir;
    assign bus.O_anim_dir = anim_dir;
    assign bus.O_anim_off = anim_off;
    assign bus.O_commit   = commit;
    assign bus.O_reject   = reject;
    assign bus.O_busy     = busy;
    assign bus.O_move_cnt = move_cnt;
    assign bus.O_gameover = gameover;
endmodule

// File: doc/hrd_move_ctrl.md
Name: hrd_move_ctrl

Overview:
- Sequences one Huarong Dao piece move per accepted direction code from the direction driver (`dir_index`).
- Per move: asks the board for a legality check, runs a fixed-length slide animation, commits the move to the board, then samples the win flag.
- Owns the move counter and the latched game-over flag. Those feed the display and the direction driver's `O_gameover` input.

Parameters:
- ANIM_STEPS, 8, number of animation offset steps per move (1..255)
- STEP_DIV, 4, clocks per animation step (>=1)
- CHK_TIMEOUT, 16, clocks to wait for `I_chk_done` before rejecting the move
- MOVE_W, 10, move counter width

Ports:
- I_clk  in  1  system clock
- I_rst_n  in  1  asynchronous active-low reset
- I_dir_index  in  3  direction code: 0 none, 1 up, 2 down, 3 left, 4 right, 5..7 invalid
- I_restart  in  1  one-cycle pulse; clears the game state
- I_chk_done  in  1  board legality answer valid (one-cycle pulse)
- I_chk_ok  in  1  move legal; qualified by `I_chk_done`
- I_win  in  1  board reports the winning configuration
- O_chk_req  out  1  legality request; held high until done or timeout
- O_chk_dir  out  3  direction under check; stable while `O_chk_req` is high
- O_anim_dir  out  3  direction being animated; 0 when not animating
- O_anim_off  out  8  current animation offset, 0..ANIM_STEPS
- O_commit  out  1  one-cycle pulse: board applies `O_anim_dir` now
- O_reject  out  1  one-cycle pulse: command refused (illegal, timeout, busy)
- O_busy  out  1  high in every state except IDLE and OVER
- O_move_cnt  out  MOVE_W  accepted-move count, saturating at all-ones
- O_gameover  out  1  latched win

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; internal previous-direction register is 0.
- Command detection:
  - A command is accepted only when the registered previous `I_dir_index` is 0 and the current value is 1..4 (rising edge of a press).
  - A held button yields one move.
  - Codes 5..7 are ignored silently.
- IDLE:
  - On a command, latch the direction into `O_chk_dir`.
  - Next cycle: `O_chk_req` = 1, state CHECK.
- CHECK:
  - Timeout counter starts at 0 and increments each cycle.
  - `I_chk_done` && `I_chk_ok`: `O_chk_req` drops; go to ANIM with `O_anim_dir` = latched direction and `O_anim_off` = 0.
  - `I_chk_done` && !`I_chk_ok`: `O_reject` pulses; go to IDLE.
  - Counter reaches CHK_TIMEOUT with no done: `O_reject` pulses; `O_chk_req` drops; go to IDLE.
  - `I_chk_done` arriving on the timeout cycle takes priority over the timeout.
- ANIM:
  - `O_anim_off` increments every STEP_DIV clocks.
  - When it reaches ANIM_STEPS, go to COMMIT.
  - Total ANIM duration is ANIM_STEPS*STEP_DIV clocks.
- COMMIT (one cycle):
  - `O_commit` = 1.
  - `O_move_cnt` increments unless already all-ones (saturates).
  - Next state WIN.
- WIN (one cycle, samples the board after its update):
  - `O_anim_dir` and `O_anim_off` return to 0.
  - If `I_win`: `O_gameover` = 1, go to OVER; else go to IDLE.
- OVER:
  - All commands ignored; no `O_reject`.
  - Leave only via `I_restart`.
- Commands arriving while busy (CHECK/ANIM/COMMIT/WIN):
  - Without the optional feature: dropped, with `O_reject` pulsed on the arrival cycle.
- `I_restart`, in any state, highest priority:
  - Next cycle: IDLE; `O_move_cnt` = 0; `O_gameover` = 0; `O_chk_req`, `O_anim_*` and the queue cleared.
  - No `O_commit` is issued for an aborted move.
- Asynchronous reset mid-move behaves identically to restart, but takes effect immediately.
- Simultaneous reject sources on one cycle produce a single `O_reject` pulse.

Optional Feature:
- Macro: HRD_CMD_QUEUE_EN.
- Defined:
  - A one-deep command buffer captures the first command that arrives while busy; no reject for it.
  - A second busy-time command while the buffer is full pulses `O_reject`.
  - On returning to IDLE from WIN or from a rejection, a buffered command is issued at once (`O_chk_req` on the following cycle).
  - The buffer is cleared on OVER entry, restart and reset.
- Undefined: no buffer; every busy-time command is rejected.

Decomposition:
- Package hrd_pkg holds:
  - direction codes DIR_NONE/UP/DOWN/LEFT/RIGHT (3-bit);
  - FSM state enum IDLE, CHECK, ANIM, COMMIT, WIN, OVER;
  - helper to validate a direction code.
- One natural sub-module, hrd_anim_timer: clock-divider counter plus step counter, with start/done, producing `O_anim_off`.

Test Plan:
- Legal move: `I_dir_index` 0→1, `I_chk_done`=`I_chk_ok`=1 two cycles after `O_chk_req` rises, ANIM_STEPS=8, STEP_DIV=4.
  - `O_chk_req` rises one cycle after the edge.
  - `O_anim_off` steps 0..8 over 32 clocks.
  - One `O_commit` pulse; `O_move_cnt`=1; `O_busy` low afterwards.
- Illegal move, and timeout:
  - `I_chk_done`=1, `I_chk_ok`=0: one `O_reject` pulse, count unchanged.
  - No done for 16 clocks: `O_chk_req` drops, one `O_reject` pulse.
- Held button: `I_dir_index`=3 held for 200 clocks → exactly one commit.
  - Invalid code 6 → no `O_chk_req`.
- Busy command: press 2 during ANIM.
  - Without queue: `O_reject` pulse that cycle.
  - With HRD_CMD_QUEUE_EN: a second `O_chk_req` with `O_chk_dir`=2 follows the first commit.
- Win: `I_win`=1 when WIN is sampled.
  - `O_gameover`=1; further presses produce no req/reject.
  - `I_restart` → `O_gameover`=0, `O_move_cnt`=0.
- Saturation and abort:
  - MOVE_W=2, five legal moves → `O_move_cnt` holds at 3.
  - Async `I_rst_n` low during ANIM → all outputs 0 immediately, no commit issued.
